// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: HI/LO registers, fixed-latency MULT/DIV with busy/stall handshake.
// Optional MADD/MSUB accumulate ops are enabled by defining E_MDU_MADD_EN.
module e_mdu #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             rd_sel,
    output logic             busy,
    output logic             stall_req,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] rd_data
);

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [2:0] OP_MADD  = 3'd6;
    localparam logic [2:0] OP_MSUB  = 3'd7;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic [WIDTH-1:0] a_q, b_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] hi_nx, lo_nx;
    logic             latch_en;

    // Ops that occupy the unit for multiple cycles and therefore stall D.
    function automatic logic is_long(input logic [2:0] op);
        case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: is_long = 1'b1;
`ifdef E_MDU_MADD_EN
            OP_MADD, OP_MSUB: is_long = 1'b1;
`endif
            default: is_long = 1'b0;
        endcase
    endfunction

    assign busy      = (state == S_BUSY);
    assign stall_req = busy | (op_valid & is_long(md_op));
    assign rd_data   = rd_sel ? lo : hi;

    // Result datapath, evaluated from latched operands at commit.
    logic                 mul_signed, div_signed;
    logic [2*WIDTH-1:0]   a_ext, b_ext, product;
    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     a_mag, b_mag, b_div, q_mag, r_mag, quot, rem;

    always_comb begin
        mul_signed = (op_q != OP_MULTU);
        a_ext   = {{WIDTH{mul_signed & a_q[WIDTH-1]}}, a_q};
        b_ext   = {{WIDTH{mul_signed & b_q[WIDTH-1]}}, b_q};
        product = a_ext * b_ext;

        // Sign-magnitude division: the most-negative / -1 case wraps back to itself naturally.
        div_signed = (op_q == OP_DIV);
        a_neg = div_signed & a_q[WIDTH-1];
        b_neg = div_signed & b_q[WIDTH-1];
        a_mag = a_neg ? (~a_q + 1'b1) : a_q;
        b_mag = b_neg ? (~b_q + 1'b1) : b_q;
        b_div = (b_q == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
        q_mag = a_mag / b_div;
        r_mag = a_mag % b_div;
        quot  = (a_neg ^ b_neg) ? (~q_mag + 1'b1) : q_mag;
        rem   = a_neg ? (~r_mag + 1'b1) : r_mag;
    end

`ifdef E_MDU_MADD_EN
    logic [2*WIDTH-1:0] acc_sum;
    always_comb begin
        acc_sum = (op_q == OP_MSUB) ? ({hi, lo} - product) : ({hi, lo} + product);
    end
`endif

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        hi_nx    = hi;
        lo_nx    = lo;
        latch_en = 1'b0;
        case (state)
            S_IDLE: begin
                if (op_valid) begin
                    case (md_op)
`ifdef E_MDU_MADD_EN
                        OP_MULT, OP_MULTU, OP_MADD, OP_MSUB: begin
`else
                        OP_MULT, OP_MULTU: begin
`endif
                            latch_en = 1'b1;
                            cnt_nx   = CW'(MUL_CYCLES);
                            state_nx = S_BUSY;
                        end
                        OP_DIV, OP_DIVU: begin
                            latch_en = 1'b1;
                            cnt_nx   = CW'(DIV_CYCLES);
                            state_nx = S_BUSY;
                        end
                        OP_MTHI: hi_nx = src_a;
                        OP_MTLO: lo_nx = src_a;
                        default: ;
                    endcase
                end
            end
            S_BUSY: begin
                if (cnt == CW'(1)) begin
                    state_nx = S_IDLE;
                    cnt_nx   = '0;
                    case (op_q)
                        OP_MULT, OP_MULTU: {hi_nx, lo_nx} = product;
                        OP_DIV, OP_DIVU: begin
                            // Divide by zero leaves HI/LO untouched.
                            if (b_q != '0) begin
                                lo_nx = quot;
                                hi_nx = rem;
                            end
                        end
`ifdef E_MDU_MADD_EN
                        OP_MADD, OP_MSUB: {hi_nx, lo_nx} = acc_sum;
`endif
                        default: ;
                    endcase
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            hi    <= hi_nx;
            lo    <= lo_nx;
            if (latch_en) begin
                a_q  <= src_a;
                b_q  <= src_b;
                op_q <= md_op;
            end
        end
    end

endmodule

// File: tb/tb_e_mdu.sv
// Directed self-checking bench for e_mdu (default parameters: 32-bit, 5-cycle multiply, 10-cycle divide).
module tb_e_mdu;

    localparam int W  = 32;
    localparam int MC = 5;
    localparam int DC = 10;

    logic         clk = 1'b0;
    logic         reset;
    logic         op_valid;
    logic [2:0]   md_op;
    logic [W-1:0] src_a, src_b;
    logic         rd_sel;
    logic         busy, stall_req;
    logic [W-1:0] hi, lo, rd_data;

    int n_vec = 0;
    int n_err = 0;

    e_mdu #(.WIDTH(W), .MUL_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .md_op(md_op),
        .src_a(src_a), .src_b(src_b), .rd_sel(rd_sel), .busy(busy),
        .stall_req(stall_req), .hi(hi), .lo(lo), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    // Presents one op across a single rising edge; returns in the sample window right after it.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        op_valid = 1'b1; md_op = op; src_a = a; src_b = b;
        @(negedge clk);
        op_valid = 1'b0; src_a = '0; src_b = '0;
    endtask

    // Counts sample windows with busy high; bounded so a stuck unit cannot hang the run.
    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; op_valid = 1'b0; md_op = '0; src_a = '0; src_b = '0; rd_sel = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++; if (hi !== 32'h0) begin n_err++; $display("FAIL reset_hi: got %h want %h", hi, 32'h0); end
        n_vec++; if (lo !== 32'h0) begin n_err++; $display("FAIL reset_lo: got %h want %h", lo, 32'h0); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if (rd_data !== 32'h0) begin n_err++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
        n_vec++; if (stall_req !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", stall_req); end
        // Start held during reset: stall follows the equation, but reset wins over the start.
        op_valid = 1'b1; md_op = 3'd2; src_a = 32'd9; src_b = 32'd3;
        #1;
        n_vec++; if (stall_req !== 1'b1) begin n_err++; $display("FAIL reset_stall_eq: got %b want 1", stall_req); end
        @(negedge clk);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_wins: busy got %b want 0", busy); end
        op_valid = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_mult();
        int n;
        @(negedge clk);
        op_valid = 1'b1; md_op = 3'd0; src_a = 32'hFFFF_FFFF; src_b = 32'd2;
        #1;
        n_vec++; if (stall_req !== 1'b1) begin n_err++; $display("FAIL mult_stall_idle: got %b want 1", stall_req); end
        @(negedge clk);
        op_valid = 1'b0;
        count_busy(n);
        n_vec++; if (n !== MC) begin n_err++; $display("FAIL mult_busy_len: got %0d want %0d", n, MC); end
        n_vec++; if (hi !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
        n_vec++; if (lo !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL mult_lo: got %h want fffffffe", lo); end
        rd_sel = 1'b0; #1;
        n_vec++; if (rd_data !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL rd_hi: got %h want ffffffff", rd_data); end
        rd_sel = 1'b1; #1;
        n_vec++; if (rd_data !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL rd_lo: got %h want fffffffe", rd_data); end
        issue(3'd1, 32'hFFFF_FFFF, 32'd2);
        count_busy(n);
        n_vec++; if (n !== MC) begin n_err++; $display("FAIL multu_busy_len: got %0d want %0d", n, MC); end
        n_vec++; if (hi !== 32'h0000_0001) begin n_err++; $display("FAIL multu_hi: got %h want 00000001", hi); end
        n_vec++; if (lo !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL multu_lo: got %h want fffffffe", lo); end
    endtask

    task automatic test_div();
        int n;
        issue(3'd2, 32'hFFFF_FFF9, 32'd2);
        count_busy(n);
        n_vec++; if (n !== DC) begin n_err++; $display("FAIL div_busy_len: got %0d want %0d", n, DC); end
        n_vec++; if (lo !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL div_lo: got %h want fffffffd", lo); end
        n_vec++; if (hi !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL div_hi: got %h want ffffffff", hi); end
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        count_busy(n);
        n_vec++; if (lo !== 32'h8000_0000) begin n_err++; $display("FAIL div_ovf_lo: got %h want 80000000", lo); end
        n_vec++; if (hi !== 32'h0) begin n_err++; $display("FAIL div_ovf_hi: got %h want 00000000", hi); end
        issue(3'd3, 32'hFFFF_FFF9, 32'd2);
        count_busy(n);
        n_vec++; if (lo !== 32'h7FFF_FFFC) begin n_err++; $display("FAIL divu_lo: got %h want 7ffffffc", lo); end
        n_vec++; if (hi !== 32'h1) begin n_err++; $display("FAIL divu_hi: got %h want 00000001", hi); end
    endtask

    task automatic test_div_zero();
        int n;
        issue(3'd4, 32'h11, 32'h0);
        n_vec++; if (hi !== 32'h11) begin n_err++; $display("FAIL mthi: got %h want 00000011", hi); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL mthi_busy: got %b want 0", busy); end
        issue(3'd5, 32'h22, 32'h0);
        n_vec++; if (lo !== 32'h22) begin n_err++; $display("FAIL mtlo: got %h want 00000022", lo); end
        issue(3'd3, 32'd7, 32'd0);
        count_busy(n);
        n_vec++; if (n !== DC) begin n_err++; $display("FAIL divz_busy_len: got %0d want %0d", n, DC); end
        n_vec++; if (hi !== 32'h11) begin n_err++; $display("FAIL divz_hi: got %h want 00000011", hi); end
        n_vec++; if (lo !== 32'h22) begin n_err++; $display("FAIL divz_lo: got %h want 00000022", lo); end
    endtask

    task automatic test_busy_ignore();
        int n;
        int stall_bad;
        issue(3'd0, 32'd3, 32'd4);
        n = 0; stall_bad = 0;
        while (busy && n < 100) begin
            n++;
            if (stall_req !== 1'b1) stall_bad++;
            op_valid = (n == 3); md_op = 3'd5; src_a = 32'h55;
            @(negedge clk);
        end
        op_valid = 1'b0;
        n_vec++; if (n !== MC) begin n_err++; $display("FAIL ign_busy_len: got %0d want %0d", n, MC); end
        n_vec++; if (stall_bad !== 0) begin n_err++; $display("FAIL ign_stall: %0d cycles low, want 0", stall_bad); end
        n_vec++; if (lo !== 32'd12) begin n_err++; $display("FAIL ign_lo: got %h want 0000000c", lo); end
        n_vec++; if (hi !== 32'd0) begin n_err++; $display("FAIL ign_hi: got %h want 00000000", hi); end
    endtask

    task automatic test_back_to_back();
        int n;
        @(negedge clk);
        op_valid = 1'b1; md_op = 3'd0; src_a = 32'd3; src_b = 32'd4;
        @(negedge clk);
        md_op = 3'd1; src_a = 32'd5; src_b = 32'd6;
        count_busy(n);
        n_vec++; if (n !== MC) begin n_err++; $display("FAIL b2b_first_len: got %0d want %0d", n, MC); end
        n_vec++; if (lo !== 32'd12) begin n_err++; $display("FAIL b2b_first_lo: got %h want 0000000c", lo); end
        @(negedge clk);
        op_valid = 1'b0;
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_accept: busy got %b want 1", busy); end
        count_busy(n);
        n_vec++; if (n !== MC) begin n_err++; $display("FAIL b2b_second_len: got %0d want %0d", n, MC); end
        n_vec++; if (lo !== 32'd30) begin n_err++; $display("FAIL b2b_second_lo: got %h want 0000001e", lo); end
        n_vec++; if (hi !== 32'd0) begin n_err++; $display("FAIL b2b_second_hi: got %h want 00000000", hi); end
    endtask

    task automatic test_madd();
`ifdef E_MDU_MADD_EN
        int n;
        issue(3'd4, 32'h0, 32'h0);
        issue(3'd5, 32'd5, 32'h0);
        issue(3'd6, 32'd3, 32'd4);
        count_busy(n);
        n_vec++; if (n !== MC) begin n_err++; $display("FAIL madd_busy_len: got %0d want %0d", n, MC); end
        n_vec++; if (lo !== 32'd17) begin n_err++; $display("FAIL madd_lo: got %h want 00000011", lo); end
        n_vec++; if (hi !== 32'd0) begin n_err++; $display("FAIL madd_hi: got %h want 00000000", hi); end
        issue(3'd7, 32'd1, 32'd18);
        count_busy(n);
        n_vec++; if (hi !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL msub_hi: got %h want ffffffff", hi); end
        n_vec++; if (lo !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL msub_lo: got %h want ffffffff", lo); end
`else
        issue(3'd4, 32'h33, 32'h0);
        issue(3'd5, 32'h44, 32'h0);
        @(negedge clk);
        op_valid = 1'b1; md_op = 3'd6; src_a = 32'd3; src_b = 32'd4;
        #1;
        n_vec++; if (stall_req !== 1'b0) begin n_err++; $display("FAIL nomadd_stall: got %b want 0", stall_req); end
        @(negedge clk);
        op_valid = 1'b0;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL nomadd_busy: got %b want 0", busy); end
        @(negedge clk);
        n_vec++; if (hi !== 32'h33) begin n_err++; $display("FAIL nomadd_hi: got %h want 00000033", hi); end
        n_vec++; if (lo !== 32'h44) begin n_err++; $display("FAIL nomadd_lo: got %h want 00000044", lo); end
`endif
    endtask

    task automatic test_reset_mid();
        int bad;
        issue(3'd4, 32'h99, 32'h0);
        issue(3'd5, 32'h98, 32'h0);
        issue(3'd2, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        n_vec++; if (hi !== 32'h0) begin n_err++; $display("FAIL rstmid_hi: got %h want 00000000", hi); end
        n_vec++; if (lo !== 32'h0) begin n_err++; $display("FAIL rstmid_lo: got %h want 00000000", lo); end
        @(negedge clk);
        reset = 1'b0;
        bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) bad++;
        end
        n_vec++; if (bad !== 0) begin n_err++; $display("FAIL rstmid_no_commit: %0d bad cycles, want 0", bad); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_busy_ignore();
        test_back_to_back();
        test_madd();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/e_mdu.md
# e_mdu

Parametrised multiply/divide unit for the E stage of the pipelined CPU. It adds HI/LO registers, multi-cycle multiply and divide with configurable latency, and a busy/stall handshake to the hazard controller. It executes MULT/MULTU/DIV/DIVU/MTHI/MTLO, and optionally MADD/MSUB. MFHI/MFLO read the registers through `rd_data`.

## Interface

Parameters:

- `WIDTH`, 32, operand and HI/LO width.
- `MUL_CYCLES`, 5, busy cycles for multiply and multiply-accumulate ops (≥1).
- `DIV_CYCLES`, 10, busy cycles for divide ops (≥1).

Ports:

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `op_valid`  in  1  E-stage instruction is an MDU op this cycle.
- `md_op`  in  3  op code:
  - 0 MULT, 1 MULTU, 2 DIV, 3 DIVU
  - 4 MTHI, 5 MTLO, 6 MADD, 7 MSUB
- `src_a`  in  WIDTH  rs operand (forwarded).
- `src_b`  in  WIDTH  rt operand (forwarded).
- `rd_sel`  in  1  0 selects HI, 1 selects LO for `rd_data`.
- `busy`  out  1  multi-cycle operation in flight.
- `stall_req`  out  1  = `busy` | (`op_valid` & `md_op` ∈ {0,1,2,3,6,7}); feeds hazard stall for any MDU instruction in D.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.
- `rd_data`  out  WIDTH  combinational `rd_sel ? lo : hi`.

## Operation

- State: `hi`, `lo`, `busy`, down-counter `cnt`, latched operands `a_q`/`b_q`, latched op `op_q`.
- **IDLE** (`busy`=0), `op_valid`=1 at an edge:
  - Op 0/1/6/7: latch operands and op, `cnt`←`MUL_CYCLES`, `busy`←1.
  - Op 2/3: same latch, `cnt`←`DIV_CYCLES`, `busy`←1.
  - Op 4: `hi`←`src_a` this edge, no busy.
  - Op 5: `lo`←`src_a` this edge, no busy.
- **BUSY**:
  - Each edge decrements `cnt`.
  - At the edge where `cnt`==1, commit the result, `busy`←0, `cnt`←0.
  - `op_valid` while busy is ignored entirely; no op is queued.
- Multiply:
  - 2·WIDTH product; signed for 0/6/7, unsigned for 1.
  - `{hi,lo}`←product.
  - MADD: `{hi,lo}`←`{hi,lo}`+product.
  - MSUB: `{hi,lo}`←`{hi,lo}`−product.
  - Accumulation wraps modulo 2^(2·WIDTH).
  - The accumulation base is `{hi,lo}` at commit time.
- Divide:
  - `lo`←quotient, truncated toward zero; `hi`←remainder, sign of dividend.
  - DIV of most-negative by −1: `lo`=0x80000000 (for WIDTH=32), `hi`=0.
  - Divisor 0 (DIV or DIVU): busy runs full `DIV_CYCLES`; `hi`/`lo` unchanged at commit.
- The result may be computed combinationally from latched operands at commit. No iterative algorithm is required; only the latency is specified.

## Timing

- Reset values:
  - `hi`=0, `lo`=0, `busy`=0, `cnt`=0.
  - `stall_req` follows its equation (0 with `op_valid`=0).
  - `rd_data`=0.
- Reset mid-operation aborts immediately and asynchronously to the reset values. No commit occurs.
- Start at edge k:
  - `busy`=1 during cycles k+1 … k+N (N = op latency).
  - The commit edge is k+N.
  - New `hi`/`lo` and `busy`=0 are visible in cycle k+N+1's sample window, i.e. right after edge k+N.
- A new start is accepted at edge k+N+1 at the earliest, since edge k+N still sees `busy`=1.
- MTHI/MTLO have 1-edge latency.
- `rd_data` is combinational from `hi`/`lo`. MFHI in D is stalled by `stall_req` while busy, so it reads committed values.
- Simultaneous start and reset: reset wins.

## Configuration

- Macro: `E_MDU_MADD_EN`.
- Defined: ops 6/7 perform MADD/MSUB as above.
- Undefined:
  - Ops 6/7 are no-ops: no latch, no busy, `hi`/`lo` unchanged.
  - `stall_req` excludes 6/7.
  - No accumulator adder is synthesised.

## Test plan

- **Signed vs unsigned multiply.** MULT `src_a`=0xFFFFFFFF, `src_b`=2 → `busy`=1 for exactly 5 cycles, then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFE. MULTU with the same operands → `hi`=0x00000001, `lo`=0xFFFFFFFE.
- **Signed and overflow divide.** DIV −7 (0xFFFFFFF9) by 2 → after 10 busy cycles `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIV 0x80000000 by 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- **Divide by zero.** MTHI 0x11, MTLO 0x22, then DIVU 7 by 0 → `busy` for 10 cycles, then `hi`=0x11, `lo`=0x22.
- **Busy and stall behaviour.** Start MULT, then assert `op_valid` with MTLO 0x55 in busy cycle 3 → ignored: `lo` = product at commit, and `stall_req`=1 throughout busy. A back-to-back start is accepted only on the first edge after `busy` falls.
- **Multiply-accumulate.** With `E_MDU_MADD_EN`: `hi`=0, `lo`=5, MADD 3,4 → `lo`=17, `hi`=0; then MSUB 1,18 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFF. Without the macro: op 6 leaves `hi`/`lo` unchanged and `busy`=0.
- **Reset mid-operation.** Assert `reset` during DIV busy cycle 4 → `busy`, `hi`, `lo` go to 0 immediately, with no later commit.
